// File: rtl/pc_sequencer.sv
// Program-counter sequencer: steps a pc through 0..PROG_LAST with stall,
// halt, jump and a saturating wrap-around counter.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | after reset; pc parked at 0, waits for start
//   RUN   | pc is a live fetch address; advances, jumps or wraps
//   STALL | pc frozen, not valid; resumes RUN when stall drops
//   HALT  | pc frozen at last value; start restarts from 0
module pc_sequencer #(
    parameter int PROG_LAST = 24,
    parameter int WIDTH     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt,
    input  logic             stall,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_addr,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    output logic [1:0]       state,
    output logic [7:0]       wraps,
    output logic             jump_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        STALL = 2'b10,
        HALT  = 2'b11
    } state_t;

    localparam logic [WIDTH-1:0] LAST = WIDTH'(PROG_LAST);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [7:0]       wraps_q, wraps_d;
    logic             jump_err_q, jump_err_d;

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            wraps_q    <= '0;
            jump_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            wraps_q    <= wraps_d;
            jump_err_q <= jump_err_d;
        end
    end

    // Next-state and next-pc selection; RUN priority is halt > stall > jump > step.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        wraps_d    = wraps_q;
        jump_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                pc_d = '0;
                if (start) begin
                    state_d = RUN;
                    wraps_d = '0;
                end
            end
            RUN: begin
                if (halt) begin
                    state_d = HALT;
                end else if (stall) begin
                    state_d = STALL;
                end else if (jump) begin
                    if (jump_addr > LAST) begin
                        pc_d       = '0;
                        jump_err_d = 1'b1;
                    end else begin
                        pc_d = jump_addr;
                    end
                end else if (pc_q == LAST) begin
                    pc_d = '0;
                    if (wraps_q != 8'hFF)
                        wraps_d = wraps_q + 8'd1;
                end else begin
                    pc_d = pc_q + WIDTH'(1);
                end
            end
            STALL: begin
                if (halt)
                    state_d = HALT;
                else if (!stall)
                    state_d = RUN;
            end
            HALT: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    wraps_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs come straight from registers or the registered state.
    assign pc       = pc_q;
    assign pc_valid = (state_q == RUN);
    assign state    = state_q;
    assign wraps    = wraps_q;
    assign jump_err = jump_err_q;

endmodule
